// File: rtl/alu_flag_reg.sv
// rtl/alu_flag_reg.sv - ALU status stage: masked NVCZ flag register, 2-entry snapshot FIFO, zero counter, zero-test error
module alu_flag_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] result,
    input  logic             zero_in,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic [3:0]       flag_mask,
    input  logic             clr_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] zero_cnt,
    output logic             err
);

    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] res_mem [2];
    logic [3:0]       flg_mem [2];

    logic             accept;
    logic             pop;
    logic [3:0]       flags_base;
    logic [3:0]       flags_new;
    logic [3:0]       flags_next;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             err_base;
    logic             err_next;
    logic             mismatch;

    // Handshake qualifiers come from registered occupancy only.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_result = out_valid ? res_mem[rd_ptr] : '0;
    assign out_flags  = out_valid ? flg_mem[rd_ptr] : 4'b0000;

    // Z follows the zero-test block; the local compare only polices it.
    assign mismatch  = zero_in != (result == '0);
    assign flags_new = {result[WIDTH-1], ovf_in, carry_in, zero_in};

    always_comb begin
        flags_base = clr_flags ? 4'b0000 : flags;
        flags_next = flags_base;
        if (accept) begin
            flags_next = (flags_base & ~flag_mask) | (flags_new & flag_mask);
        end
    end

    always_comb begin
        cnt_base = clr_flags ? '0 : zero_cnt;
        cnt_next = cnt_base;
        if (accept) begin
            if (!zero_in) begin
                cnt_next = '0;
            end else if (!(&cnt_base)) begin
                cnt_next = cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        err_base = clr_flags ? 1'b0 : err;
        err_next = err_base | (accept & mismatch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags    <= 4'b0000;
            zero_cnt <= '0;
            err      <= 1'b0;
        end else begin
            flags    <= flags_next;
            zero_cnt <= cnt_next;
            err      <= err_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            res_mem[0] <= '0;
            res_mem[1] <= '0;
            flg_mem[0] <= 4'b0000;
            flg_mem[1] <= 4'b0000;
        end else begin
            // Snapshot carries the same flag value FLAGS takes on this edge.
            if (accept) begin
                res_mem[wr_ptr] <= result;
                flg_mem[wr_ptr] <= flags_next;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flag_reg.sv
// tb/tb_alu_flag_reg.sv - directed self-checking bench for alu_flag_reg
module tb_alu_flag_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             zero_in;
    logic             carry_in;
    logic             ovf_in;
    logic [3:0]       flag_mask;
    logic             clr_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [3:0]       flags;
    logic [CNT_W-1:0] zero_cnt;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_flag_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .result     (result),
        .zero_in    (zero_in),
        .carry_in   (carry_in),
        .ovf_in     (ovf_in),
        .flag_mask  (flag_mask),
        .clr_flags  (clr_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .flags      (flags),
        .zero_cnt   (zero_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cyc(input logic iv, input logic [7:0] res, input logic z, input logic c,
                       input logic o, input logic [3:0] mask, input logic clr, input logic ordy);
        in_valid  = iv;
        result    = res;
        zero_in   = z;
        carry_in  = c;
        ovf_in    = o;
        flag_mask = mask;
        clr_flags = clr;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, ordy);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; result = '0; zero_in = 1'b0; carry_in = 1'b0; ovf_in = 1'b0;
        flag_mask = 4'b0000; clr_flags = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_flags", flags, 4'b0000);
        check("rst_zero_cnt", zero_cnt, 0);
        check("rst_err", err, 0);
        check("rst_out_result", out_result, 8'h00);
        rst = 1'b0;

        // First accept: zero result with carry
        cyc(1, 8'h00, 1, 1, 0, 4'b1111, 0, 0);
        check("t1_flags", flags, 4'b0011);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_result", out_result, 8'h00);
        check("t1_out_flags", out_flags, 4'b0011);
        check("t1_zero_cnt", zero_cnt, 1);
        check("t1_err", err, 0);
        check("t1_in_ready", in_ready, 1);
        idle(1);
        check("t1_drained", out_valid, 0);

        // Backpressure: two pushes fill, third waits for a pop
        cyc(1, 8'h80, 0, 0, 0, 4'b1000, 0, 0);
        check("t2_flags_n", flags, 4'b1011);
        check("t2_zero_cnt", zero_cnt, 0);
        check("t2_in_ready1", in_ready, 1);
        cyc(1, 8'h01, 0, 0, 0, 4'b0000, 0, 0);
        check("t2_in_ready_full", in_ready, 0);
        cyc(1, 8'h02, 0, 0, 0, 4'b1111, 0, 0);
        check("t2_blocked_flags", flags, 4'b1011);
        check("t2_hold_result", out_result, 8'h80);
        check("t2_hold_flags", out_flags, 4'b1011);
        check("t2_still_full", in_ready, 0);
        cyc(1, 8'h02, 0, 0, 0, 4'b0000, 0, 1);
        check("t2_pop1_result", out_result, 8'h01);
        check("t2_pop1_ready", in_ready, 1);
        cyc(1, 8'h02, 0, 0, 0, 4'b0000, 0, 1);
        check("t2_pushpop_result", out_result, 8'h02);
        check("t2_pushpop_valid", out_valid, 1);
        idle(1);
        check("t2_empty", out_valid, 0);
        check("t2_empty_result", out_result, 8'h00);

        // Masked update: only Z may change
        cyc(1, 8'h80, 0, 1, 1, 4'b1111, 0, 1);
        check("t3_setup_flags", flags, 4'b1110);
        cyc(1, 8'h00, 1, 0, 0, 4'b0000, 0, 1);
        check("t3_setup_cnt", zero_cnt, 1);
        cyc(1, 8'h05, 0, 0, 0, 4'b0001, 0, 1);
        check("t3_flags", flags, 4'b1110);
        check("t3_zero_cnt", zero_cnt, 0);
        check("t3_out_flags", out_flags, 4'b1110);
        idle(1);

        // Counter saturation at CNT_W=2
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp_cnt;
            exp_cnt = (i < 3) ? i + 1 : 3;
            cyc(1, 8'h00, 1, 0, 0, 4'b0000, 0, 1);
            check($sformatf("t4_cnt%0d", i), zero_cnt, exp_cnt);
        end
        cyc(1, 8'h07, 0, 0, 0, 4'b0000, 0, 1);
        check("t4_cnt_reset", zero_cnt, 0);
        idle(1);

        // Zero-test disagreement and clear with simultaneous accept
        cyc(1, 8'h10, 1, 0, 0, 4'b0001, 0, 1);
        check("t5_err_set", err, 1);
        check("t5_flags_z", flags, 4'b1111);
        cyc(1, 8'h20, 0, 0, 0, 4'b0000, 0, 1);
        check("t5_err_sticky", err, 1);
        cyc(1, 8'h00, 1, 0, 0, 4'b0001, 1, 1);
        check("t5_clr_flags", flags, 4'b0001);
        check("t5_clr_cnt", zero_cnt, 1);
        check("t5_clr_err", err, 0);
        check("t5_clr_out_flags", out_flags, 4'b0001);
        idle(1);

        // Asynchronous reset with a full buffer
        cyc(1, 8'h11, 0, 1, 0, 4'b1111, 0, 0);
        cyc(1, 8'h22, 0, 0, 0, 4'b1111, 0, 0);
        check("t6_full", in_ready, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_flags", flags, 4'b0000);
        check("t6_rst_zero_cnt", zero_cnt, 0);
        check("t6_rst_out_result", out_result, 8'h00);
        #2 rst = 1'b0;
        cyc(1, 8'h93, 0, 1, 0, 4'b1111, 0, 0);
        check("t6_new_result", out_result, 8'h93);
        check("t6_new_flags", out_flags, 4'b1010);
        check("t6_in_ready", in_ready, 1);
        idle(1);
        check("t6_no_stale", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_flag_reg.md
# alu_flag_reg

Registered status stage directly downstream of the ALU result path and its zero-test block. It accepts each 8-bit ALU result together with the zero-test output and the ALU carry/overflow, maintains the architectural flag register (N, V, C, Z) under a per-flag update mask, and buffers result-plus-flag snapshots in a 2-entry FIFO with a valid/ready handshake toward the consumer. It also counts consecutive zero results and raises a sticky error when the zero-test input disagrees with the result it accompanies.

## Interface
- WIDTH, 8, result width in bits. N is taken from RESULT[WIDTH-1].
- CNT_W, 8, width of the consecutive-zero counter, which saturates at all-ones.

- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  upstream result present.
- IN_READY  out  1  buffer can accept; 1 when occupancy < 2. Depends on registered state only.
- RESULT  in  WIDTH  ALU result.
- ZERO_IN  in  1  zero-test output; 1 means RESULT == 0.
- CARRY_IN  in  1  ALU carry out.
- OVF_IN  in  1  ALU signed overflow.
- FLAG_MASK  in  4  update enables, bit order {N,V,C,Z}; a 1 bit updates that flag on accept.
- CLR_FLAGS  in  1  synchronous clear of FLAGS, ZERO_CNT and ERR.
- OUT_VALID  out  1  head entry present.
- OUT_READY  in  1  consumer takes head.
- OUT_RESULT  out  WIDTH  head entry result.
- OUT_FLAGS  out  4  head entry flag snapshot, order {N,V,C,Z}.
- FLAGS  out  4  current architectural flags, order {N,V,C,Z}.
- ZERO_CNT  out  CNT_W  consecutive accepted results with ZERO_IN=1.
- ERR  out  1  sticky; set when ZERO_IN != (RESULT == 0) on an accept.

## Operation
- Accept: IN_VALID & IN_READY at a rising edge. Pop: OUT_VALID & OUT_READY at a rising edge.
- Flag update on each edge:
  - Start from base = CLR_FLAGS ? 0 : FLAGS.
  - If accepting, each masked bit is replaced: Z<-ZERO_IN, C<-CARRY_IN, V<-OVF_IN, N<-RESULT[WIDTH-1]. Unmasked bits keep base.
  - FLAGS takes the result.
- Snapshot: an accepted entry stores RESULT and the post-update flag value, i.e. the same value FLAGS takes on that edge.
- Z is taken from ZERO_IN, not recomputed. The local comparison RESULT==0 feeds only the ERR check.
- ZERO_CNT:
  - Base is 0 if CLR_FLAGS is asserted, otherwise the current value.
  - On accept: base+1 (saturating at 2^CNT_W-1) if ZERO_IN=1; 0 if ZERO_IN=0.
  - Without accept: holds base.
- ERR: base is 0 if CLR_FLAGS is asserted, otherwise the current value. It is set to 1 on an accept with a mismatch, and otherwise holds base.
- FIFO:
  - Two entries, in-order, with occupancy 0..2.
  - Push and pop on the same edge leave occupancy unchanged. This is legal only at occupancy 1, since IN_READY=0 at occupancy 2.
  - Pointers wrap modulo 2.
- IN_VALID without IN_READY: no state change. FLAGS, ZERO_CNT and ERR do not update, but CLR_FLAGS still applies.
- Reset (asynchronous, at any time, including mid-transfer): occupancy 0 and pending entries discarded; OUT_VALID=0, IN_READY=1, FLAGS=0000, ZERO_CNT=0, ERR=0. OUT_RESULT and OUT_FLAGS read 0 while empty.

## Timing
- Latency: an accept at edge k gives OUT_VALID=1 after edge k when the buffer was empty, and FLAGS updates after the same edge.
- Throughput: 1 result/cycle while OUT_READY=1.
- With OUT_READY=0: two results are accepted, then IN_READY=0 after the second accepting edge.
- Bubble: from the full state, one pop re-enables IN_READY the next cycle. There is no combinational path from OUT_READY to IN_READY.
- OUT_RESULT and OUT_FLAGS are stable while OUT_VALID=1 and OUT_READY=0.
- All outputs are driven from registers or from a register-selected mux; there are no input-to-output combinational paths.

## Test plan
- Reset, then accept RESULT=0x00, ZERO_IN=1, CARRY_IN=1, OVF_IN=0, MASK=1111 -> next cycle FLAGS=0011, OUT_VALID=1, OUT_RESULT=0x00, OUT_FLAGS=0011, ZERO_CNT=1, ERR=0.
- OUT_READY=0; push 0x80 (MASK=1000), then 0x01, then 0x02 -> IN_READY=0 after the second push and the third is not taken. Drain gives OUT_RESULT 0x80 with OUT_FLAGS N=1, then 0x01. 0x02 is accepted after the first pop.
- MASK=0001 with prior FLAGS=1110; accept 0x05, ZERO_IN=0 -> FLAGS=1110. ZERO_CNT=0 if it was nonzero.
- CNT_W=2; five consecutive ZERO_IN=1 accepts of 0x00 -> ZERO_CNT 1,2,3,3,3. Then accept 0x07, ZERO_IN=0 -> ZERO_CNT=0.
- Accept RESULT=0x10 with ZERO_IN=1 -> ERR=1 and Z=1. ERR stays 1 through later clean accepts until CLR_FLAGS; CLR_FLAGS with a simultaneous accept of 0x00, ZERO_IN=1, MASK=0001 -> FLAGS=0001, ZERO_CNT=1, ERR=0.
- Fill both entries, assert RST mid-cycle for less than one period -> OUT_VALID=0, IN_READY=1, FLAGS=0, ZERO_CNT=0 immediately, without waiting for a clock edge. The next accept shows the new data with no stale entry.
